// File: rtl/ov7670_frame_meter.sv
// OV7670 frame timing meter: bytes/frame, lines/frame, last-line bytes and frame count from HREF/VSYNC.
// Latency: results and frame_valid appear the cycle after the frame-ending VSYNC rise; LEDs add one cycle after sel.
// Backpressure: none; a passive observer of the camera timing, it never stalls the capture path.
// Optional: define OV7670_LINE_CHECK_EN to add line_err (per-frame line-length consistency flag).
module ov7670_frame_meter #(
  parameter int BYTE_W  = 20,
  parameter int LINE_W  = 10,
  parameter int LBYTE_W = 12,
  parameter int FRAME_W = 8,
  parameter int LED_W   = 16
) (
  input  logic             reloj,
  input  logic             rst,
  input  logic             HREF,
  input  logic             VSYNC,
  input  logic             mode,
  input  logic             arm,
  input  logic [1:0]       sel,
  output logic [LED_W-1:0] LEDs,
  output logic             frame_valid,
  output logic             busy,
  output logic             ovf
`ifdef OV7670_LINE_CHECK_EN
  ,
  output logic             line_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic past_href, past_vsync;
  logic vs_rise, active, line_open, close_line;
  logic clr_work, end_frame, cnt_en, sat_event, ovf_clr;

  logic [BYTE_W-1:0]  byte_cnt, res_bytes;
  logic [LINE_W-1:0]  line_cnt, res_lines, line_inc;
  logic [LBYTE_W-1:0] lbyte_cnt, last_lbyte, res_last;
  logic [FRAME_W-1:0] frame_cnt;

  assign vs_rise = VSYNC & ~past_vsync;
  assign active  = HREF & ~VSYNC;
  // A line is open when the previous cycle carried an active byte; it closes when
  // HREF drops or when VSYNC rises underneath a still-high HREF.
  assign line_open  = past_href & ~past_vsync;
  assign close_line = line_open & (~HREF | VSYNC);
  assign line_inc   = (&line_cnt) ? line_cnt : line_cnt + LINE_W'(1);

  assign sat_event = (cnt_en & active & ((&byte_cnt) | (&lbyte_cnt)))
                   | ((cnt_en | end_frame) & close_line & (&line_cnt));

  // State register.
  always_ff @(posedge reloj) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    clr_work  = 1'b0;
    end_frame = 1'b0;
    cnt_en    = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        busy = 1'b1;
        if (vs_rise) begin
          clr_work = 1'b1;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        busy = 1'b1;
        if (vs_rise) begin
          end_frame = 1'b1;
          clr_work  = 1'b1;
          state_d   = mode ? COUNT : DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        if (arm) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge history, working counters, result latches and overflow flag.
  always_ff @(posedge reloj) begin
    if (rst) begin
      past_href   <= 1'b0;
      past_vsync  <= 1'b0;
      frame_valid <= 1'b0;
      ovf_clr     <= 1'b0;
      ovf         <= 1'b0;
      byte_cnt    <= '0;
      line_cnt    <= '0;
      lbyte_cnt   <= '0;
      last_lbyte  <= '0;
      res_bytes   <= '0;
      res_lines   <= '0;
      res_last    <= '0;
      frame_cnt   <= '0;
    end else begin
      past_href   <= HREF;
      past_vsync  <= VSYNC;
      frame_valid <= end_frame;
      ovf_clr     <= clr_work;

      if (end_frame) begin
        res_bytes <= byte_cnt;
        res_lines <= close_line ? line_inc : line_cnt;
        res_last  <= close_line ? lbyte_cnt : last_lbyte;
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end

      if (clr_work) begin
        byte_cnt   <= '0;
        line_cnt   <= '0;
        lbyte_cnt  <= '0;
        last_lbyte <= '0;
      end else if (cnt_en) begin
        if (active) begin
          if (!(&byte_cnt))  byte_cnt  <= byte_cnt + BYTE_W'(1);
          if (!(&lbyte_cnt)) lbyte_cnt <= lbyte_cnt + LBYTE_W'(1);
        end
        if (close_line) begin
          line_cnt   <= line_inc;
          last_lbyte <= lbyte_cnt;
          lbyte_cnt  <= '0;
        end
      end

      // The frame-end result keeps its flag visible for one cycle, then the new frame starts clean.
      if (sat_event)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Registered LED source mux; every value is zero-extended or truncated to LED_W.
  always_ff @(posedge reloj) begin
    if (rst) begin
      LEDs <= '0;
    end else begin
      case (sel)
        2'd0:    LEDs <= LED_W'(32'(res_bytes));
        2'd1:    LEDs <= LED_W'(32'(res_lines));
        2'd2:    LEDs <= LED_W'(32'(res_last));
        default: LEDs <= LED_W'(32'(frame_cnt));
      endcase
    end
  end

`ifdef OV7670_LINE_CHECK_EN
  logic [LBYTE_W-1:0] ref_lbyte;
  logic               have_ref;

  // First closed line of a frame sets the reference length; later mismatches stick until the next frame.
  always_ff @(posedge reloj) begin
    if (rst) begin
      ref_lbyte <= '0;
      have_ref  <= 1'b0;
      line_err  <= 1'b0;
    end else if (clr_work) begin
      ref_lbyte <= '0;
      have_ref  <= 1'b0;
      line_err  <= 1'b0;
    end else if (cnt_en && close_line) begin
      if (!have_ref) begin
        ref_lbyte <= lbyte_cnt;
        have_ref  <= 1'b1;
      end else if (lbyte_cnt != ref_lbyte) begin
        line_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_frame_meter.sv
// Directed bench for ov7670_frame_meter: expected frame results are queued as each frame is driven
// and compared through the LED mux after the frame-ending VSYNC rise.
// A second instance with BYTE_W=4 shares the stimulus to exercise byte-counter saturation.
module tb_ov7670_frame_meter;

  logic        reloj = 1'b0;
  logic        rst, HREF, VSYNC, mode, arm;
  logic [1:0]  sel;
  logic [15:0] LEDs, LEDs_s;
  logic        frame_valid, busy, ovf;
  logic        frame_valid_s, busy_s, ovf_s;
`ifdef OV7670_LINE_CHECK_EN
  logic        line_err, line_err_s;
`endif

  typedef struct packed {
    logic [31:0] bytes;
    logic [31:0] lines;
    logic [31:0] last;
    logic [31:0] fcnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          fv_cnt   = 0;
  logic        ovf_at_end, ovf_s_at_end;
  logic [15:0] leds_s[4];

  always #5 reloj = ~reloj;

  ov7670_frame_meter dut (
    .reloj(reloj), .rst(rst), .HREF(HREF), .VSYNC(VSYNC), .mode(mode), .arm(arm), .sel(sel),
    .LEDs(LEDs), .frame_valid(frame_valid), .busy(busy), .ovf(ovf)
`ifdef OV7670_LINE_CHECK_EN
    , .line_err(line_err)
`endif
  );

  ov7670_frame_meter #(.BYTE_W(4)) dut_s (
    .reloj(reloj), .rst(rst), .HREF(HREF), .VSYNC(VSYNC), .mode(mode), .arm(arm), .sel(sel),
    .LEDs(LEDs_s), .frame_valid(frame_valid_s), .busy(busy_s), .ovf(ovf_s)
`ifdef OV7670_LINE_CHECK_EN
    , .line_err(line_err_s)
`endif
  );

  // Count every frame_valid cycle of the main instance.
  always @(negedge reloj) if (frame_valid === 1'b1) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) begin
      HREF = 1'b1;
      tick();
    end
    HREF = 1'b0;
    repeat (3) tick();
  endtask

  task automatic vs_start();
    VSYNC = 1'b1;
    repeat (3) tick();
    VSYNC = 1'b0;
    repeat (2) tick();
  endtask

  task automatic push_exp(input int b, input int l, input int lb, input int f);
    exp_t e;
    e.bytes = b; e.lines = l; e.last = lb; e.fcnt = f;
    exp_q.push_back(e);
  endtask

  task automatic sweep_zero();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      @(negedge reloj);
      chk("leds_after_rst", LEDs, 0);
    end
    sel = 2'd0;
  endtask

  // Raise VSYNC to end a frame, then read every result back through the LED mux.
  task automatic frame_end(input bit upd, input bit exp_busy);
    exp_t        e;
    int          fv0;
    logic [31:0] want;
    string       tags[4];
    tags[0] = "leds_bytes"; tags[1] = "leds_lines"; tags[2] = "leds_last"; tags[3] = "leds_fcnt";
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    fv0   = fv_cnt;
    VSYNC = 1'b1;
    tick();
    @(negedge reloj);
    chk("frame_valid", frame_valid, upd);
    chk("busy_at_end", busy, exp_busy);
    ovf_at_end   = ovf;
    ovf_s_at_end = ovf_s;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      @(negedge reloj);
      case (s)
        0:       want = e.bytes;
        1:       want = e.lines;
        2:       want = e.last;
        default: want = e.fcnt;
      endcase
      chk(tags[s], LEDs, want);
      leds_s[s] = LEDs_s;
    end
    chk("fv_pulses", fv_cnt - fv0, upd);
    chk("ovf_main", ovf_at_end, 0);
    sel   = 2'd0;
    VSYNC = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1; HREF = 1'b0; VSYNC = 1'b0; mode = 1'b0; arm = 1'b0; sel = 2'd0;

    // Reset held three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge reloj);
      chk("rst_leds", LEDs, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fv", frame_valid, 0);
      chk("rst_ovf", ovf, 0);
    end
    rst = 1'b0;
    tick();
    @(negedge reloj);
    chk("idle_leds", LEDs, 0);
    chk("idle_busy", busy, 0);

    // Single-shot: partial frame discarded, then one 4x6 frame.
    mode = 1'b0;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
    @(negedge reloj);
    chk("armed_busy", busy, 1);
    line(6);
    line(6);
    vs_start();
    chk("no_fv_on_start", fv_cnt, 0);
    for (int i = 0; i < 4; i++) line(6);
    push_exp(24, 4, 6, 1);
    frame_end(1'b1, 1'b0);
    // A later frame in DONE must not update anything.
    line(3);
    line(3);
    push_exp(24, 4, 6, 1);
    frame_end(1'b0, 1'b0);

    // Continuous mode, fresh from reset: 2x5, 3x5, 4x5.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    mode = 1'b1;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
    vs_start();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < f + 2; i++) line(5);
      push_exp((f + 2) * 5, f + 2, 5, f + 1);
      frame_end(1'b1, 1'b1);
    end

    // Byte saturation on the BYTE_W=4 instance, then a normal frame clears ovf.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    vs_start();
    for (int i = 0; i < 3; i++) line(8);
    push_exp(24, 3, 8, 1);
    frame_end(1'b1, 1'b1);
    chk("small_ovf_set", ovf_s_at_end, 1);
    chk("small_bytes_sat", leds_s[0], 15);
    chk("small_lines", leds_s[1], 3);
    line(4);
    line(4);
    push_exp(8, 2, 4, 2);
    frame_end(1'b1, 1'b1);
    chk("small_ovf_clr", ovf_s_at_end, 0);
    chk("small_bytes", leds_s[0], 8);
    @(negedge reloj);
    chk("small_ovf_idle", ovf_s, 0);

    // Reset in the middle of line 2, then re-arm and measure a clean 2x4 frame.
    mode = 1'b0;
    line(4);
    HREF = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    HREF = 1'b0;
    @(negedge reloj);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf", ovf, 0);
    sweep_zero();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    vs_start();
    line(4);
    line(4);
    push_exp(8, 2, 4, 1);
    frame_end(1'b1, 1'b0);

`ifdef OV7670_LINE_CHECK_EN
    // Line lengths 6, 6, 5: error at the third line end, cleared by the frame end.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    vs_start();
    line(6);
    line(6);
    for (int i = 0; i < 5; i++) begin
      HREF = 1'b1;
      tick();
    end
    HREF = 1'b0;
    @(negedge reloj);
    chk("line_err_before", line_err, 0);
    tick();
    @(negedge reloj);
    chk("line_err_set", line_err, 1);
    repeat (2) tick();
    push_exp(17, 3, 5, 2);
    VSYNC = 1'b1;
    tick();
    @(negedge reloj);
    chk("line_err_clr", line_err, 0);
    VSYNC = 1'b0;
    repeat (2) tick();
    exp_q.pop_front();
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
